// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources.
// A one-entry stage captures the winner on the rising edge and drives the write port and per-register enables.
module rf_write_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       wr_stall,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_addr,
    output logic [DATA_W-1:0]          rf_data,
    output logic [(2**ADDR_W)-1:0]     rf_dec,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy
);

    localparam int unsigned GID_W = $clog2(NREQ);
    localparam int unsigned SUM_W = GID_W + 1;

    logic                 r_sv;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_data;
    logic [GID_W-1:0]     r_gid;
    logic [GID_W-1:0]     r_ptr;

    logic                 w_accept;
    logic [2*NREQ-1:0]    w_dbl;
    logic [NREQ-1:0]      w_rot;
    logic                 w_found;
    logic [GID_W-1:0]     w_off;
    logic [SUM_W-1:0]     w_sum;
    logic [GID_W-1:0]     w_win;
    logic [GID_W-1:0]     w_ptr_nxt;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_data;
    logic [ADDR_W-1:0]    w_addr_arr [NREQ];
    logic [DATA_W-1:0]    w_data_arr [NREQ];

    // Unpack the flat request buses into per-requester entries.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign w_data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // The stage can take a new entry when empty or when its write drains this cycle.
    assign w_accept = !r_sv || !wr_stall;

    // Rotate so bit 0 is the pointer position; the first set bit is the winner's offset.
    assign w_dbl = {req_valid, req_valid} >> r_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_off   = GID_W'(j);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win     = (w_sum >= SUM_W'(NREQ)) ? GID_W'(w_sum - SUM_W'(NREQ)) : GID_W'(w_sum);
    assign w_ptr_nxt = (w_win == GID_W'(NREQ - 1)) ? '0 : w_win + GID_W'(1);

    assign w_sel_addr = w_addr_arr[w_win];
    assign w_sel_data = w_data_arr[w_win];

    // Ready is held low during reset so no requester sees a grant it cannot complete.
    assign req_ready = (clr && w_found && w_accept) ? (NREQ'(1) << w_win) : '0;

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sv   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_gid  <= '0;
            r_ptr  <= '0;
        end else if (w_accept) begin
            if (w_found) begin
                r_sv   <= 1'b1;
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
                r_gid  <= w_win;
                r_ptr  <= w_ptr_nxt;
            end else begin
                r_sv   <= 1'b0;
            end
        end
    end

    // Writes to register 0 are consumed but never reach the bank.
    assign rf_we    = r_sv && !wr_stall && (r_addr != '0);
    assign rf_addr  = r_addr;
    assign rf_data  = r_data;
    assign grant_id = r_gid;
    assign busy     = r_sv;

    always_comb begin
        rf_dec         = '0;
        rf_dec[r_addr] = rf_we;
    end

endmodule
